// File: rtl/note_glyph_renderer_pkg.sv
// Shared types and constants for the note label renderer: 12x12 glyph bitmaps,
// note codes and the FSM state encoding. Bitmaps are row-major, MSB = top-left.
package note_glyph_renderer_pkg;

  localparam int GLYPH_W    = 12;
  localparam int GLYPH_H    = 12;
  localparam int GLYPH_BITS = GLYPH_W * GLYPH_H;
  localparam int NUM_GLYPHS = 3;

  typedef logic [GLYPH_BITS-1:0] bitmap_t;

  // Each group of three hex digits is one 12-pixel bitmap row, top row first.
  localparam bitmap_t BM_A     = 144'h000_0F0_198_30C_30C_3FC_3FC_30C_30C_30C_30C_000;
  localparam bitmap_t BM_B     = 144'h000_3F0_318_30C_318_3F0_3F0_318_30C_318_3F0_000;
  localparam bitmap_t BM_C     = 144'h000_0F8_18C_300_300_300_300_300_300_18C_0F8_000;
  localparam bitmap_t BM_D     = 144'h000_3F0_318_30C_30C_30C_30C_30C_30C_318_3F0_000;
  localparam bitmap_t BM_E     = 144'h000_3FC_300_300_300_3F8_3F8_300_300_300_3FC_000;
  localparam bitmap_t BM_F     = 144'h000_3FC_300_300_300_3F8_3F8_300_300_300_300_000;
  localparam bitmap_t BM_G     = 144'h000_0F8_18C_300_300_33C_30C_30C_30C_18C_0F8_000;
  localparam bitmap_t BM_SHARP = 144'h000_090_090_3FC_090_090_090_3FC_090_090_000_000;
  localparam bitmap_t BM_1     = 144'h000_060_0E0_1E0_060_060_060_060_060_060_1F8_000;
  localparam bitmap_t BM_2     = 144'h000_0F0_198_00C_00C_018_030_060_0C0_180_3FC_000;
  localparam bitmap_t BM_3     = 144'h000_0F0_198_00C_018_070_018_00C_00C_198_0F0_000;
  localparam bitmap_t BM_4     = 144'h000_018_038_078_0D8_198_318_3FC_018_018_018_000;

  localparam logic [3:0] NOTE_A  = 4'd1;
  localparam logic [3:0] NOTE_AS = 4'd2;
  localparam logic [3:0] NOTE_B  = 4'd3;
  localparam logic [3:0] NOTE_C  = 4'd4;
  localparam logic [3:0] NOTE_CS = 4'd5;
  localparam logic [3:0] NOTE_D  = 4'd6;
  localparam logic [3:0] NOTE_DS = 4'd7;
  localparam logic [3:0] NOTE_E  = 4'd8;
  localparam logic [3:0] NOTE_F  = 4'd9;
  localparam logic [3:0] NOTE_FS = 4'd10;
  localparam logic [3:0] NOTE_G  = 4'd11;
  localparam logic [3:0] NOTE_GS = 4'd12;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRAW,
    ST_ERASE,
    ST_FINISH
  } state_e;

  function automatic logic is_sharp(input logic [3:0] note);
    return note inside {NOTE_AS, NOTE_CS, NOTE_DS, NOTE_FS, NOTE_GS};
  endfunction

endpackage

// File: rtl/note_glyph_renderer_rom.sv
// Combinational glyph lookup: picks the sharp, letter or octave-digit bitmap
// for the selected glyph slot. Invalid notes yield blank sharp/letter slots.
module note_glyph_renderer_rom
  import note_glyph_renderer_pkg::*;
(
  input  logic [3:0] note,
  input  logic [1:0] octave,
  input  logic [1:0] glyph_idx,
  output bitmap_t    bitmap
);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    bitmap = '0;
    unique case (glyph_idx)
      2'd0: if (is_sharp(note)) bitmap = BM_SHARP;
      2'd1: begin
        case (note)
          NOTE_A, NOTE_AS: bitmap = BM_A;
          NOTE_B:          bitmap = BM_B;
          NOTE_C, NOTE_CS: bitmap = BM_C;
          NOTE_D, NOTE_DS: bitmap = BM_D;
          NOTE_E:          bitmap = BM_E;
          NOTE_F, NOTE_FS: bitmap = BM_F;
          NOTE_G, NOTE_GS: bitmap = BM_G;
          default:         bitmap = '0;
        endcase
      end
      2'd2: begin
        unique case (octave)
          2'd0: bitmap = BM_1;
          2'd1: bitmap = BM_2;
          2'd2: bitmap = BM_3;
          2'd3: bitmap = BM_4;
        endcase
      end
      default: bitmap = '0;
    endcase
  end

endmodule

// File: rtl/note_glyph_renderer.sv
// Scans a 3-glyph note label (sharp, letter, octave) pixel by pixel into the VGA
// adapter's write port, scaled by SCALE, with off-screen pixels suppressed.
module note_glyph_renderer
  import note_glyph_renderer_pkg::*;
#(
  parameter int         SCALE     = 1,
  parameter int         X_W       = 8,
  parameter int         Y_W       = 7,
  parameter int         SCREEN_W  = 160,
  parameter int         SCREEN_H  = 120,
  parameter logic [2:0] FG_COLOUR = 3'b100,
  parameter logic [2:0] BG_COLOUR = 3'b000
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic [3:0]     note,
  input  logic [1:0]     octave,
  input  logic [X_W-1:0] x,
  input  logic [Y_W-1:0] y,
  input  logic           ld_note,
  input  logic           clr_note,
  output logic           busy,
  output logic           done,
  output logic [X_W-1:0] x_out,
  output logic [Y_W-1:0] y_out,
  output logic           writeEn,
  output logic [2:0]     colour
);

  localparam int         XS      = X_W + 1;
  localparam int         YS      = Y_W + 1;
  localparam logic [1:0] SUB_MAX = 2'(SCALE - 1);

  state_e state, state_nxt;

  logic [3:0]     note_q;
  logic [1:0]     oct_q;
  logic [X_W-1:0] x_q;
  logic [Y_W-1:0] y_q;

  logic [1:0] glyph_cnt, srow_cnt, scol_cnt;
  logic [3:0] row_cnt, col_cnt;

  logic last_scol, last_col, last_srow, last_row, last_glyph, last_pix;
  logic start, scanning;

  bitmap_t        bitmap;
  logic [7:0]     bit_idx;
  logic           pix_bit;
  logic [XS-1:0]  x_sum;
  logic [YS-1:0]  y_sum;
  logic           in_view;

  assign start    = (state == ST_IDLE) && (ld_note || clr_note);
  assign scanning = (state == ST_DRAW) || (state == ST_ERASE);

  assign last_scol  = (scol_cnt == SUB_MAX);
  assign last_col   = (col_cnt == 4'(GLYPH_W - 1));
  assign last_srow  = (srow_cnt == SUB_MAX);
  assign last_row   = (row_cnt == 4'(GLYPH_H - 1));
  assign last_glyph = (glyph_cnt == 2'(NUM_GLYPHS - 1));
  assign last_pix   = last_scol && last_col && last_srow && last_row && last_glyph;

  always_ff @(posedge clk) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (clr_note)     state_nxt = ST_ERASE;
        else if (ld_note) state_nxt = ST_DRAW;
      end
      ST_DRAW, ST_ERASE: if (last_pix) state_nxt = ST_FINISH;
      ST_FINISH:         state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      note_q    <= '0;
      oct_q     <= '0;
      x_q       <= '0;
      y_q       <= '0;
      glyph_cnt <= '0;
      row_cnt   <= '0;
      srow_cnt  <= '0;
      col_cnt   <= '0;
      scol_cnt  <= '0;
    end else if (start) begin
      note_q    <= note;
      oct_q     <= octave;
      x_q       <= x;
      y_q       <= y;
      glyph_cnt <= '0;
      row_cnt   <= '0;
      srow_cnt  <= '0;
      col_cnt   <= '0;
      scol_cnt  <= '0;
    end else if (scanning) begin
      // Odometer: sub-col fastest, glyph slowest; everything wraps to 0 after the last pixel.
      scol_cnt <= last_scol ? '0 : scol_cnt + 2'd1;
      if (last_scol) begin
        col_cnt <= last_col ? '0 : col_cnt + 4'd1;
        if (last_col) begin
          srow_cnt <= last_srow ? '0 : srow_cnt + 2'd1;
          if (last_srow) begin
            row_cnt <= last_row ? '0 : row_cnt + 4'd1;
            if (last_row) glyph_cnt <= last_glyph ? '0 : glyph_cnt + 2'd1;
          end
        end
      end
    end
  end

  note_glyph_renderer_rom u_rom (
    .note      (note_q),
    .octave    (oct_q),
    .glyph_idx (glyph_cnt),
    .bitmap    (bitmap)
  );

  assign bit_idx = 8'(GLYPH_BITS - 1) - (8'(row_cnt) * 8'(GLYPH_W) + 8'(col_cnt));
  assign pix_bit = bitmap[bit_idx];

  // One extra bit of headroom so a box hanging off the right/bottom edge clips instead of wrapping.
  assign x_sum = {1'b0, x_q} + XS'(glyph_cnt) * XS'(GLYPH_W * SCALE)
               + XS'(col_cnt) * XS'(SCALE) + XS'(scol_cnt);
  assign y_sum = {1'b0, y_q} + YS'(row_cnt) * YS'(SCALE) + YS'(srow_cnt);
  assign in_view = (x_sum < XS'(SCREEN_W)) && (y_sum < YS'(SCREEN_H));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      writeEn <= 1'b0;
      x_out   <= '0;
      y_out   <= '0;
      colour  <= BG_COLOUR;
    end else begin
      done    <= 1'b0;
      writeEn <= 1'b0;
      unique case (state)
        ST_IDLE: if (start) busy <= 1'b1;
        ST_DRAW, ST_ERASE: begin
          writeEn <= in_view;
          x_out   <= x_sum[X_W-1:0];
          y_out   <= y_sum[Y_W-1:0];
          colour  <= (state == ST_DRAW && pix_bit) ? FG_COLOUR : BG_COLOUR;
        end
        ST_FINISH: begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_note_glyph_renderer.sv
// Self-checking bench: a reference scan model pushes expected pixels to a queue at
// request time; each DUT output cycle pops and compares one entry.
module tb_note_glyph_renderer;
  import note_glyph_renderer_pkg::*;

  localparam logic [2:0] FG = 3'b100;
  localparam logic [2:0] BG = 3'b000;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [3:0] note = '0;
  logic [1:0] octave = '0;
  logic [7:0] x = '0;
  logic [6:0] y = '0;
  logic       ld1 = 1'b0, clr1 = 1'b0, ld2 = 1'b0, clr2 = 1'b0;

  logic       busy1, done1, we1, busy2, done2, we2;
  logic [7:0] xo1, xo2;
  logic [6:0] yo1, yo2;
  logic [2:0] col1, col2;

  bit         sel_big = 1'b0;
  logic       busy_s, done_s, we_s;
  logic [7:0] xo_s;
  logic [6:0] yo_s;
  logic [2:0] col_s;

  always #5 clk = ~clk;

  note_glyph_renderer #(.SCALE(1)) dut1 (
    .clk(clk), .resetn(resetn), .note(note), .octave(octave), .x(x), .y(y),
    .ld_note(ld1), .clr_note(clr1), .busy(busy1), .done(done1),
    .x_out(xo1), .y_out(yo1), .writeEn(we1), .colour(col1)
  );

  note_glyph_renderer #(.SCALE(2)) dut2 (
    .clk(clk), .resetn(resetn), .note(note), .octave(octave), .x(x), .y(y),
    .ld_note(ld2), .clr_note(clr2), .busy(busy2), .done(done2),
    .x_out(xo2), .y_out(yo2), .writeEn(we2), .colour(col2)
  );

  assign busy_s = sel_big ? busy2 : busy1;
  assign done_s = sel_big ? done2 : done1;
  assign we_s   = sel_big ? we2   : we1;
  assign xo_s   = sel_big ? xo2   : xo1;
  assign yo_s   = sel_big ? yo2   : yo1;
  assign col_s  = sel_big ? col2  : col1;

  typedef struct packed {
    logic       busy;
    logic [7:0] x;
    logic [6:0] y;
    logic       we;
    logic [2:0] c;
  } pix_t;

  pix_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  int           n_writes, n_nonbg, n_sharp_nonbg, min_x, max_x, min_y, max_y;
  logic [143:0] obs_letter;

  function automatic logic [143:0] ref_bitmap(input logic [3:0] n, input logic [1:0] o, input int g);
    logic [143:0] digits [4] = '{BM_1, BM_2, BM_3, BM_4};
    if (g == 2) return digits[o];
    if (g == 0) return (n == 2 || n == 5 || n == 7 || n == 10 || n == 12) ? BM_SHARP : '0;
    case (n)
      4'd1, 4'd2:  return BM_A;
      4'd3:        return BM_B;
      4'd4, 4'd5:  return BM_C;
      4'd6, 4'd7:  return BM_D;
      4'd8:        return BM_E;
      4'd9, 4'd10: return BM_F;
      4'd11, 4'd12: return BM_G;
      default:     return '0;
    endcase
  endfunction

  task automatic push_expected(input logic [3:0] n, input logic [1:0] o, input logic [7:0] xx,
                               input logic [6:0] yy, input bit erase, input int s);
    logic [143:0] bm;
    pix_t p;
    int px, py;
    for (int g = 0; g < 3; g++) begin
      bm = ref_bitmap(n, o, g);
      for (int r = 0; r < 12; r++)
        for (int sr = 0; sr < s; sr++)
          for (int c = 0; c < 12; c++)
            for (int sc = 0; sc < s; sc++) begin
              px     = int'(xx) + g * 12 * s + c * s + sc;
              py     = int'(yy) + r * s + sr;
              p.busy = 1'b1;
              p.x    = 8'(px);
              p.y    = 7'(py);
              p.we   = (px < 160) && (py < 120);
              p.c    = (!erase && bm[143 - (r * 12 + c)]) ? FG : BG;
              exp_q.push_back(p);
            end
    end
  endtask

  // Drives one request, then pops/compares one expected pixel per cycle.
  // poke_at > 0 injects a ld_note pulse (poke_reset=0) or a reset (poke_reset=1) after that pixel.
  task automatic run_op(input string tag, input bit big, input logic [3:0] n, input logic [1:0] o,
                        input logic [7:0] xx, input logic [6:0] yy, input bit do_ld, input bit do_clr,
                        input bit hold, input int poke_at, input bit poke_reset);
    int   s;
    int   total;
    int   rx, ry;
    pix_t got, want;
    s     = big ? 2 : 1;
    total = 432 * s * s;
    n_writes = 0; n_nonbg = 0; n_sharp_nonbg = 0;
    min_x = 1000; max_x = -1; min_y = 1000; max_y = -1;
    obs_letter = '0;
    exp_q.delete();
    sel_big = big;
    note = n; octave = o; x = xx; y = yy;
    if (big) begin ld2 = do_ld; clr2 = do_clr; end
    else     begin ld1 = do_ld; clr1 = do_clr; end
    push_expected(n, o, xx, yy, do_clr, s);
    @(posedge clk); #1;
    clr1 = 1'b0; clr2 = 1'b0;
    if (!hold) begin ld1 = 1'b0; ld2 = 1'b0; end
    note = ~n; octave = ~o; x = xx + 8'd37; y = yy ^ 7'h15;
    checks++;
    if (busy_s !== 1'b1) begin
      errors++;
      $display("FAIL %s busy_on_accept: got %b expected 1", tag, busy_s);
    end
    for (int i = 1; i <= total; i++) begin
      @(posedge clk); #1;
      if (!hold) begin ld1 = 1'b0; ld2 = 1'b0; end
      got  = '{busy: busy_s, x: xo_s, y: yo_s, we: we_s, c: col_s};
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL %s pixel %0d: got busy=%b x=%0d y=%0d we=%b colour=%b, expected busy=%b x=%0d y=%0d we=%b colour=%b",
                 tag, i, got.busy, got.x, got.y, got.we, got.c, want.busy, want.x, want.y, want.we, want.c);
      end
      if (we_s === 1'b1) begin
        n_writes++;
        if (col_s !== BG) n_nonbg++;
        if (int'(xo_s) < min_x) min_x = int'(xo_s);
        if (int'(xo_s) > max_x) max_x = int'(xo_s);
        if (int'(yo_s) < min_y) min_y = int'(yo_s);
        if (int'(yo_s) > max_y) max_y = int'(yo_s);
        rx = int'(xo_s) - int'(xx);
        ry = int'(yo_s) - int'(yy);
        if (rx >= 0 && rx < 12 * s && col_s !== BG) n_sharp_nonbg++;
        if (s == 1 && rx >= 12 && rx < 24 && ry >= 0 && ry < 12)
          obs_letter[143 - (ry * 12 + (rx - 12))] = (col_s === FG);
      end
      if (i == poke_at) begin
        if (poke_reset) begin
          resetn = 1'b0;
          @(posedge clk); #1;
          checks++;
          if (we_s !== 1'b0 || busy_s !== 1'b0 || done_s !== 1'b0) begin
            errors++;
            $display("FAIL %s after_reset: got we=%b busy=%b done=%b expected 0 0 0", tag, we_s, busy_s, done_s);
          end
          resetn = 1'b1;
          repeat (5) begin
            @(posedge clk); #1;
            checks++;
            if (done_s !== 1'b0 || busy_s !== 1'b0 || we_s !== 1'b0) begin
              errors++;
              $display("FAIL %s post_reset_quiet: got done=%b busy=%b we=%b expected 0 0 0", tag, done_s, busy_s, we_s);
            end
          end
          exp_q.delete();
          return;
        end else begin
          if (big) ld2 = 1'b1; else ld1 = 1'b1;
        end
      end
    end
    @(posedge clk); #1;
    checks++;
    if (done_s !== 1'b1 || busy_s !== 1'b0 || we_s !== 1'b0) begin
      errors++;
      $display("FAIL %s done_pulse: got done=%b busy=%b we=%b expected 1 0 0", tag, done_s, busy_s, we_s);
    end
    @(posedge clk); #1;
    checks++;
    if (done_s !== 1'b0 || busy_s !== hold || we_s !== 1'b0) begin
      errors++;
      $display("FAIL %s after_done: got done=%b busy=%b we=%b expected 0 %b 0", tag, done_s, busy_s, we_s, hold);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy1, done1, we1, xo1, yo1, col1} !== {1'b0, 1'b0, 1'b0, 8'd0, 7'd0, BG}) begin
      errors++;
      $display("FAIL reset_s1: got busy=%b done=%b we=%b x=%0d y=%0d colour=%b expected all 0",
               busy1, done1, we1, xo1, yo1, col1);
    end
    checks++;
    if ({busy2, done2, we2, xo2, yo2, col2} !== {1'b0, 1'b0, 1'b0, 8'd0, 7'd0, BG}) begin
      errors++;
      $display("FAIL reset_s2: got busy=%b done=%b we=%b x=%0d y=%0d colour=%b expected all 0",
               busy2, done2, we2, xo2, yo2, col2);
    end
    resetn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_draw_sharp();
    run_op("draw_a_sharp", 1'b0, 4'd2, 2'd0, 8'd10, 7'd20, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    checks++;
    if (n_writes != 432) begin
      errors++;
      $display("FAIL draw_a_sharp write_count: got %0d expected 432", n_writes);
    end
  endtask

  task automatic test_draw_natural();
    run_op("draw_b", 1'b0, 4'd3, 2'd2, 8'd10, 7'd20, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    checks++;
    if (n_sharp_nonbg != 0) begin
      errors++;
      $display("FAIL draw_b sharp_blank: got %0d non-BG writes expected 0", n_sharp_nonbg);
    end
    checks++;
    if (obs_letter !== BM_B) begin
      errors++;
      $display("FAIL draw_b letter_bitmap: got %h expected %h", obs_letter, BM_B);
    end
  endtask

  task automatic test_erase_priority();
    run_op("erase_wins", 1'b0, 4'd2, 2'd3, 8'd0, 7'd0, 1'b1, 1'b1, 1'b0, 0, 1'b0);
    checks++;
    if (n_writes != 432 || n_nonbg != 0) begin
      errors++;
      $display("FAIL erase_wins count: got writes=%0d nonbg=%0d expected 432 0", n_writes, n_nonbg);
    end
    checks++;
    if (min_x != 0 || max_x != 35 || min_y != 0 || max_y != 11) begin
      errors++;
      $display("FAIL erase_wins span: got x=%0d..%0d y=%0d..%0d expected x=0..35 y=0..11",
               min_x, max_x, min_y, max_y);
    end
  endtask

  task automatic test_clip();
    run_op("clip_s2", 1'b1, 4'd12, 2'd3, 8'd150, 7'd115, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    checks++;
    if (n_writes != 50 || max_x != 159 || max_y != 119) begin
      errors++;
      $display("FAIL clip_s2 window: got writes=%0d max_x=%0d max_y=%0d expected 50 159 119",
               n_writes, max_x, max_y);
    end
  endtask

  task automatic test_busy_request();
    run_op("ld_while_busy", 1'b0, 4'd6, 2'd1, 8'd10, 7'd20, 1'b1, 1'b0, 1'b0, 100, 1'b0);
    checks++;
    if (n_writes != 432) begin
      errors++;
      $display("FAIL ld_while_busy write_count: got %0d expected 432", n_writes);
    end
  endtask

  task automatic test_reset_mid();
    run_op("reset_mid", 1'b0, 4'd8, 2'd2, 8'd10, 7'd20, 1'b1, 1'b0, 1'b0, 50, 1'b1);
    run_op("after_reset", 1'b0, 4'd9, 2'd3, 8'd40, 7'd60, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    checks++;
    if (n_writes != 432) begin
      errors++;
      $display("FAIL after_reset write_count: got %0d expected 432", n_writes);
    end
  endtask

  task automatic test_back_to_back();
    // ld_note held through a whole draw: ignored while busy, re-accepted once IDLE returns.
    run_op("held_ld", 1'b0, 4'd15, 2'd1, 8'd100, 7'd100, 1'b1, 1'b0, 1'b1, 0, 1'b0);
    ld1 = 1'b0;
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_draw_sharp();
    test_draw_natural();
    test_erase_priority();
    test_clip();
    test_busy_request();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
